// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - B_in, LSB first, one bit per clock.
// Result and final borrow are registered and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             D_ser
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             bw;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             bw_nx;
  logic [WIDTH-1:0] r_nx;

  assign a0    = a_sh[0];
  assign b0    = b_sh[0];
  assign d     = a0 ^ b0 ^ bw;
  assign bw_nx = (~a0 & b0) | (~(a0 ^ b0) & bw);
  assign D_ser = (state == SHIFT) & d;

  // new difference bit enters at the MSB
  assign r_nx = (r_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      B_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            bw    <= B_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nx;
          bw   <= bw_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            Diff  <= r_nx;
            B_out <= bw_nx;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8).
// Stimulus pushes expected {borrow,diff}; a monitor pops on each done.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       B_in;
  logic       busy;
  logic       done;
  logic [7:0] Diff;
  logic       B_out;
  logic       D_ser;

  int vectors;
  int miscompares;
  int ndone;
  int cyc;
  logic [8:0] sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .B_in  (B_in),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .B_out (B_out),
    .D_ser (D_ser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  // monitor: every done pulse must match the oldest expectation
  logic [8:0] exp_m;
  always @(negedge clk) begin
    if (rst_n && done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_m = sb.pop_front();
        chk("diff", {24'd0, Diff}, {24'd0, exp_m[7:0]});
        chk("b_out", {31'd0, B_out}, {31'd0, exp_m[8]});
      end
    end
  end

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      @(negedge clk);
      if (!busy && !done && sb.size() == 0) ok = 1;
    end
    if (ok == 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // one operation with latency, busy-length and serial-stream checks
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    logic [8:0] e;
    logic [7:0] ser;
    int nb;
    int dat;
    wait_idle();
    e = model(a, b, bin);
    A = a;
    B = b;
    B_in = bin;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    dat = 0;
    ser = '0;
    for (int c = 1; c <= 20 && dat == 0; c++) begin
      if (busy) begin
        ser = {D_ser, ser[7:1]};
        nb++;
      end
      if (done) dat = c;
      if (dat == 0) @(negedge clk);
    end
    chk("done_latency", dat, 9);
    chk("busy_cycles", nb, 8);
    chk("d_ser_stream", {24'd0, ser}, {24'd0, e[7:0]});
  endtask

  logic [7:0] va[4];
  logic [7:0] vb[4];
  logic       vc[4];

  initial begin
    int nd0;
    int prev;
    int got;
    logic pbusy;
    vectors = 0;
    miscompares = 0;
    ndone = 0;
    cyc = 0;
    start = 0;
    A = 0;
    B = 0;
    B_in = 0;
    rst_n = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_dser", {31'd0, D_ser}, 0);
    chk("rst_diff", {24'd0, Diff}, 0);
    chk("rst_bout", {31'd0, B_out}, 0);
    #20;
    @(negedge clk);
    rst_n = 1;

    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1);
    run_op(8'h00, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'hFF, 8'h00, 1'b0);

    // start and operands toggled during SHIFT and DONE are ignored
    wait_idle();
    nd0 = ndone;
    A = 8'h5A;
    B = 8'h3C;
    B_in = 0;
    start = 1;
    sb.push_back(model(8'h5A, 8'h3C, 1'b0));
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    start = 1;
    A = 8'hFF;
    B = 8'h01;
    B_in = 1;
    @(negedge clk);
    start = 0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("ign_done_seen", got, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    chk("ign_busy_after", {31'd0, busy}, 0);
    chk("ign_one_done", ndone - nd0, 1);

    // reset in the middle of SHIFT
    wait_idle();
    nd0 = ndone;
    A = 8'h33;
    B = 8'h11;
    B_in = 0;
    start = 1;
    sb.push_back(model(8'h33, 8'h11, 1'b0));
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 0;
    sb.delete();
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_dser", {31'd0, D_ser}, 0);
    chk("mid_rst_diff", {24'd0, Diff}, 0);
    chk("mid_rst_bout", {31'd0, B_out}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", ndone - nd0, 0);
    run_op(8'h10, 8'h01, 1'b0);

    // start held high: one acceptance every 10 cycles
    va = '{8'h12, 8'h00, 8'hC3, 8'h7E};
    vb = '{8'h34, 8'h00, 8'h3C, 8'h7F};
    vc = '{1'b0, 1'b1, 1'b1, 1'b0};
    wait_idle();
    start = 1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      A = va[i];
      B = vb[i];
      B_in = vc[i];
      sb.push_back(model(va[i], vb[i], vc[i]));
      got = 0;
      pbusy = busy;
      for (int c = 0; c < 30 && got == 0; c++) begin
        @(negedge clk);
        if (busy && !pbusy) got = 1;
        pbusy = busy;
      end
      chk("b2b_accept", got, 1);
      if (i > 0) chk("b2b_period", cyc - prev, 10);
      prev = cyc;
      A = ~va[i];
      B = ~vb[i];
      if (i == 3) start = 0;
    end
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous assertion, active-low.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits, the minuend; captured when start is accepted.
REQ-006 The block SHALL have port B, input, WIDTH bits, the subtrahend; captured when start is accepted.
REQ-007 The block SHALL have port B_in, input, 1 bit, the borrow-in; captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit, high while in SHIFT.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the result becomes valid.
REQ-010 The block SHALL have port Diff, output, WIDTH bits, the registered difference A-B-B_in mod 2^WIDTH.
REQ-011 The block SHALL have port B_out, output, 1 bit, the registered final borrow.
REQ-012 The block SHALL have port D_ser, output, 1 bit, the current serial difference bit; valid only while busy=1, LSB first.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL capture A, B and B_in into shift/borrow registers, clear the bit counter, and go to SHIFT.
REQ-015 In SHIFT, each cycle the block SHALL apply a full subtractor to the operand LSBs a, b and the borrow register bw: d = a^b^bw, bw_next = (~a&b) | (~(a^b)&bw).
REQ-016 In SHIFT, at each edge the block SHALL shift both operand registers right by one, shift d into the MSB of the result register, update bw, and increment the counter.
REQ-017 D_ser SHALL equal the combinational d of the current SHIFT cycle, and SHALL be 0 outside SHIFT.
REQ-018 The block SHALL remain in SHIFT for exactly WIDTH cycles, then go to DONE.
REQ-019 On entering DONE, Diff SHALL hold the complete result and B_out the final bw; done SHALL be 1 for exactly the one DONE cycle, after which the block returns to IDLE.
REQ-020 Latency SHALL be as follows: start sampled at edge k, done=1 in the cycle following edge k+WIDTH, and the next start accepted at edge k+WIDTH+2.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no queuing.
REQ-022 Diff and B_out SHALL update only on entry to DONE and SHALL hold until the next completed operation; they SHALL NOT change while in SHIFT.
REQ-023 Input changes on A, B and B_in after capture SHALL have no effect on the operation in progress.
REQ-024 The operand counter SHALL be ceil(log2(WIDTH+1)) bits wide, and the block SHALL NOT wrap early.
REQ-025 The result SHALL be modulo 2^WIDTH, with B_out=1 exactly when A < B+B_in (unsigned).

Reset
REQ-026 When rst_n=0, asynchronously: state=IDLE; busy=0; done=0; D_ser=0; Diff=0; B_out=0; counter, operand and borrow registers=0.
REQ-027 Reset mid-SHIFT SHALL abort the operation, and no done pulse SHALL be produced for it.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 Stimulus A=0x5A, B=0x3C, B_in=0, start one cycle -> Diff=0x1E, B_out=0, done pulse 9 cycles after start edge, busy high 8 cycles.
REQ-030 Stimulus A=0x00, B=0x01, B_in=0 -> Diff=0xFF, B_out=1; D_ser sequence 1,1,1,1,1,1,1,1.
REQ-031 Stimulus A=0x80, B=0x7F, B_in=1 -> Diff=0x00, B_out=0; and A=0x00, B=0xFF, B_in=1 -> Diff=0x00, B_out=1.
REQ-032 Stimulus start re-pulsed and A/B changed during SHIFT -> first result unaffected, exactly one done pulse, no second operation begun.
REQ-033 Stimulus rst_n pulsed low at SHIFT cycle 4 -> all outputs 0 immediately, no done pulse; a subsequent start with A=0x10, B=0x01 -> Diff=0x0F.
REQ-034 Stimulus back-to-back start held high continuously -> operations start every 10 cycles, each with correct Diff; randomized run of 1000 operations compared against A-B-B_in.
